// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command/response codes and frame helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Bits leave LSB first: data[7:0], odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte request/response bundle
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus consecutive-sample level filter
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Idle PS/2 lines float high, so reset to 1 avoids a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_CYCLES   = 20,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2_host_tx_if.slave    tx_if,
  input  logic            ps2_clk_i,
  input  logic            ps2_data_i,
  output logic            ps2_clk_oe_o,
  output logic            ps2_data_oe_o
);

  localparam int CNT_MAX0 = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > START_CYCLES) ? CNT_MAX0 : START_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  ps2_tx_state_t state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_smp_q, ack_smp_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;
  logic             clk_lvl, data_lvl, clk_lvl_q;
  logic             clk_fall, timing_out;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (ps2_clk_i),
    .level_o (clk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (ps2_data_i),
    .level_o (data_lvl)
  );

  assign clk_fall   = clk_lvl_q & ~clk_lvl;
  assign timing_out = (state_q == ST_SHIFT || state_q == ST_WAIT_ACK || state_q == ST_WAIT_IDLE)
                      && !clk_fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_smp_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      clk_lvl_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_smp_q <= ack_smp_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
      clk_lvl_q <= clk_lvl;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_smp_d = ack_smp_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_if.tx_valid) begin
          state_d   = ST_INHIBIT;
          shift_d   = ps2_frame(tx_if.tx_data);
          bit_cnt_d = '0;
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = ST_START;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          clk_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          cnt_d     = '0;
          if (bit_cnt_q == 4'd9) state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (clk_fall) begin
          ack_smp_d = data_lvl;
          cnt_d     = '0;
          state_d   = ST_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done_d    = 1'b1;
          ack_err_d = ack_smp_q;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A silent device must never leave the bus held; abort overrides everything.
    if (timing_out) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      ack_err_d = 1'b0;
      cnt_d     = '0;
    end
  end

  assign tx_if.tx_ready = (state_q == ST_IDLE);
  assign tx_if.busy     = (state_q != ST_IDLE);
  assign tx_if.done     = done_q;
  assign tx_if.ack_err  = ack_err_q;
  assign tx_if.timeout  = timeout_q;
  assign ps2_clk_oe_o   = clk_oe_q;
  assign ps2_data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with open-drain device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 40;
  localparam int STC  = 8;
  localparam int FL   = 4;
  localparam int TO   = 600;
  localparam int HALF = 30;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_TO    = 2;
  localparam int M_HOLD  = 3;
  localparam int M_ABORT = 4;

  typedef struct {
    logic [9:0] frame;
    logic       ack_err;
    logic       timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic clk_oe, data_oe;
  logic ps2_clk_pin, ps2_data_pin;
  logic ready_chk = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t       exp_q[$];
  logic [9:0] rx_q[$];
  exp_t       e_cur;
  logic [9:0] rx_cur;

  ps2_host_tx_if tx_if ();

  assign ps2_clk_pin  = dev_clk & ~clk_oe;
  assign ps2_data_pin = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_if         (tx_if),
    .ps2_clk_i     (ps2_clk_pin),
    .ps2_data_i    (ps2_data_pin),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Device: clocks nf falls, samples host DATA at the end of each low phase.
  task automatic dev_run(input int nf, input bit ack, input bit glitch);
    logic [9:0] f;
    f = '0;
    for (int k = 1; k <= nf; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      if (glitch && k == 5) begin
        repeat (10) tick();
        dev_clk = 1'b0;
        repeat (FL - 1) tick();
        dev_clk = 1'b1;
        repeat (HALF - 10 - (FL - 1)) tick();
      end else begin
        repeat (HALF) tick();
      end
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (k <= 10) f[k-1] = ps2_data_pin;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
    end
    if (nf == 11) rx_q.push_back(f);
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] frm, input int mode, input string nm);
    int k;
    if (mode != M_ABORT)
      exp_q.push_back('{frame: frm, ack_err: (mode == M_NACK), timeout: (mode == M_TO)});
    @(negedge clk);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    tick();
    if (mode == M_HOLD) tx_if.tx_data = 8'h55;
    else tx_if.tx_valid = 1'b0;
    check({nm, "_clk_oe_on_accept"}, 32'(clk_oe), 32'(1));
    check({nm, "_ready_low"}, 32'(tx_if.tx_ready), 32'(0));
    k = 0;
    while (!data_oe && k < INH + 50) begin tick(); k++; end
    check({nm, "_inhibit_len"}, 32'(k), 32'(INH));
    k = 0;
    while (clk_oe && k < STC + 50) begin tick(); k++; end
    check({nm, "_start_len"}, 32'(k), 32'(STC));
    if (mode == M_ABORT) begin
      dev_run(4, 1'b1, 1'b0);
      return;
    end
    if (mode == M_TO) begin
      k = 0;
      while (!tx_if.done && k < TO + 100) begin tick(); k++; end
      check({nm, "_timeout_len"}, 32'(k), 32'(TO));
    end else begin
      dev_run(11, mode != M_NACK, mode == M_HOLD);
    end
    tx_if.tx_valid = 1'b0;
    k = 0;
    while (!tx_if.tx_ready && k < 200) begin tick(); k++; end
    check({nm, "_return_idle"}, 32'(tx_if.tx_ready), 32'(1));
    repeat (3) tick();
  endtask

  // Scoreboard monitor: every DONE pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ready_chk) begin
        check("ready_after_done", 32'(tx_if.tx_ready), 32'(1));
        ready_chk = 1'b0;
      end
      if (tx_if.done === 1'b1) begin
        ready_chk = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(tx_if.done), 32'(0));
        end else begin
          e_cur = exp_q.pop_front();
          check("ack_err", 32'(tx_if.ack_err), 32'(e_cur.ack_err));
          check("timeout", 32'(tx_if.timeout), 32'(e_cur.timeout));
          check("oe_released", 32'({clk_oe, data_oe}), 32'(0));
          if (!e_cur.timeout) begin
            if (rx_q.size() == 0) begin
              check("rx_frame_present", 32'(rx_q.size()), 32'(1));
            end else begin
              rx_cur = rx_q.pop_front();
              check("frame_bits", 32'(rx_cur), 32'(e_cur.frame));
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    repeat (3) tick();
    check("rst_clk_oe", 32'(clk_oe), 32'(0));
    check("rst_data_oe", 32'(data_oe), 32'(0));
    check("rst_ready", 32'(tx_if.tx_ready), 32'(1));
    check("rst_busy", 32'(tx_if.busy), 32'(0));
    check("rst_done", 32'({tx_if.done, tx_if.ack_err, tx_if.timeout}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    send(CMD_SET_LED, 10'h3ED, M_ACK,  "ed");
    send(8'h00,       10'h300, M_ACK,  "x00");
    send(CMD_RESET,   10'h3FF, M_HOLD, "ff_hold_glitch");
    send(8'h01,       10'h201, M_ACK,  "x01");
    send(CMD_ENABLE,  10'h2F4, M_NACK, "nack");
    send(CMD_SET_LED, 10'h3ED, M_TO,   "tmo");

    send(8'h00, 10'h300, M_ABORT, "abort");
    repeat (10) tick();
    check("abort_data_oe_before_rst", 32'(data_oe), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_oe_async_clear", 32'({clk_oe, data_oe}), 32'(0));
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_ready_after_rst", 32'(tx_if.tx_ready), 32'(1));
    check("abort_busy_after_rst", 32'(tx_if.busy), 32'(0));
    repeat (3) tick();

    send(CMD_ENABLE, 10'h2F4, M_ACK, "f4_after_rst");

    repeat (20) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
